// File: rtl/pipelined_adder.sv
// Chunked add/subtract pipeline: each stage adds one CW-bit slice, least significant first,
// with a ready/valid handshake on both sides and a global stall when the output is blocked.
module pipelined_adder #(
    parameter int unsigned SIZE   = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            sub,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [SIZE-1:0] out,
    output logic            carry,
    output logic            overflow,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int unsigned CW   = SIZE / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if ((SIZE < 2) || (STAGES < 1) || (STAGES > SIZE) || ((SIZE % STAGES) != 0)) begin : g_param_err
        $error("pipelined_adder: illegal SIZE/STAGES combination");
    end

    logic [STAGES-1:0] vld_q, vld_d, vld_src;
    logic [SIZE-1:0]   a_q   [STAGES];
    logic [SIZE-1:0]   a_d   [STAGES];
    logic [SIZE-1:0]   a_src [STAGES];
    logic [SIZE-1:0]   b_q   [STAGES];
    logic [SIZE-1:0]   b_d   [STAGES];
    logic [SIZE-1:0]   b_src [STAGES];
    logic [SIZE-1:0]   r_q   [STAGES];
    logic [SIZE-1:0]   r_d   [STAGES];
    logic [SIZE-1:0]   r_src [STAGES];
    logic              c_q   [STAGES];
    logic              c_d   [STAGES];
    logic              cin   [STAGES];
    logic [CW:0]       sum   [STAGES];
    logic              ovf_q, ovf_d;
    logic              adv;

    // Stage inputs: stage 0 takes the ports, stage k takes the skew registers of stage k-1.
    always_comb begin
        adv        = out_ready | ~vld_q[LAST];
        vld_src    = '0;
        vld_src[0] = in_valid;
        a_src[0]   = a;
        b_src[0]   = sub ? ~b : b;
        r_src[0]   = '0;
        cin[0]     = sub;
        for (int k = 1; k < STAGES; k++) begin
            vld_src[k] = vld_q[k-1];
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            r_src[k]   = r_q[k-1];
            cin[k]     = c_q[k-1];
        end
    end

    // Per-stage chunk add and next-state; data only loads with a valid transaction.
    always_comb begin
        vld_d = vld_q;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            sum[k] = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, b_src[k][k*CW +: CW]}
                   + (CW+1)'(cin[k]);
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            r_d[k] = r_q[k];
            c_d[k] = c_q[k];
            if (adv) begin
                vld_d[k] = vld_src[k];
            end
            if (adv && vld_src[k]) begin
                a_d[k]                = a_src[k];
                b_d[k]                = b_src[k];
                r_d[k]                = r_src[k];
                r_d[k][k*CW +: CW]    = sum[k][CW-1:0];
                c_d[k]                = sum[k][CW];
            end
        end
        if (adv && vld_src[LAST]) begin
            ovf_d = (a_src[LAST][SIZE-1] == b_src[LAST][SIZE-1]) &&
                    (sum[LAST][CW-1] != a_src[LAST][SIZE-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out       = r_q[LAST];
    assign carry     = c_q[LAST];
    assign overflow  = ovf_q;
    assign out_valid = vld_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed vectors on an 8-bit/2-stage instance,
// plus 32-bit instances with one stage and with 32 stages.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a, b;
    logic       sub, in_valid, out_ready;
    logic       in_ready, carry, overflow, out_valid;
    logic [7:0] out;

    pipelined_adder #(.SIZE(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sub(sub), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .carry(carry), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    logic [31:0] a32, b32, o1, o32;
    logic        iv1, iv32, ir1, ir32, c1, c32, v1, v32, ov1, ov32;

    pipelined_adder #(.SIZE(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .sub(1'b0), .in_valid(iv1),
        .in_ready(ir1), .out(o1), .carry(c1), .overflow(v1),
        .out_valid(ov1), .out_ready(1'b1)
    );

    pipelined_adder #(.SIZE(32), .STAGES(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .sub(1'b0), .in_valid(iv32),
        .in_ready(ir32), .out(o32), .carry(c32), .overflow(v32),
        .out_valid(ov32), .out_ready(1'b1)
    );

    typedef struct packed {
        logic [7:0] out;
        logic       c;
        logic       v;
    } res_t;

    // Directed vectors with hand-computed {out, carry, overflow}.
    localparam int NV = 12;
    logic [7:0] va [NV] = '{8'hFF, 8'h7F, 8'h80, 8'h12, 8'h50, 8'h80, 8'h00, 8'h05, 8'hC8, 8'h7F, 8'h3C, 8'hFF};
    logic [7:0] vb [NV] = '{8'h01, 8'h01, 8'h01, 8'h34, 8'h70, 8'h80, 8'h01, 8'h03, 8'h9C, 8'h80, 8'h0F, 8'hFF};
    logic       vs [NV] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    res_t       ve [NV] = '{'{8'h00, 1'b1, 1'b0}, '{8'h80, 1'b0, 1'b1}, '{8'h7F, 1'b1, 1'b1},
                            '{8'h46, 1'b0, 1'b0}, '{8'hE0, 1'b0, 1'b0}, '{8'h00, 1'b1, 1'b1},
                            '{8'hFF, 1'b0, 1'b0}, '{8'h02, 1'b1, 1'b0}, '{8'h64, 1'b1, 1'b1},
                            '{8'hFF, 1'b0, 1'b1}, '{8'h4B, 1'b0, 1'b0}, '{8'h00, 1'b1, 1'b0}};

    res_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: got out=%0h with no pending transaction", out);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("result", {23'd0, out, carry, overflow}, {23'd0, e.out, e.c, e.v});
            end
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    // Drive vector i at a negedge, wait for in_ready, leave at the negedge after acceptance.
    task automatic send(input int i, input bit expect_out);
        int n = 0;
        a = va[i]; b = vb[i]; sub = vs[i]; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: vector %0d never accepted, in_ready=%0b required 1", i, in_ready);
        end else if (expect_out) begin
            sb.push_back(ve[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a = '0; b = '0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a32 = '0; b32 = '0; iv1 = 1'b0; iv32 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out",       32'(out),       32'd0);
        check("reset_carry",     32'(carry),     32'd0);
        check("reset_overflow",  32'(overflow),  32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_ov32",      32'(ov32),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transaction: exactly 2-cycle latency, valid for one cycle.
        send(0, 1'b1);
        #1 check("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 check("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1 check("lat_cycle3_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Back-to-back stream of all vectors.
        max_run = 0;
        for (int i = 0; i < NV; i++) send(i, 1'b1);
        drain();
        check("stream_consecutive", 32'(max_run), 32'(NV));

        // Stall: fill with out_ready low, hold for 5 cycles, then release.
        @(negedge clk);
        out_ready = 1'b0;
        send(4, 1'b1);
        send(8, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out",       32'(out),       32'(ve[4].out));
            check("stall_overflow",  32'(overflow),  32'(ve[4].v));
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(9, 1'b1);
        send(2, 1'b1);
        drain();

        // Reset with two transactions in flight discards both.
        @(negedge clk);
        send(1, 1'b0);
        send(8, 1'b0);
        rst_n = 1'b0;
        #1 check("inflight_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out",       32'(out),       32'd0);
        check("flush_carry",     32'(carry),     32'd0);
        check("flush_overflow",  32'(overflow),  32'd0);
        check("flush_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 check("post_flush_quiet", 32'(out_valid), 32'd0);
        end

        // 32-bit, one stage: latency 1.
        begin
            int n;
            @(negedge clk);
            a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; iv1 = 1'b1;
            @(negedge clk);
            iv1 = 1'b0;
            n = 1;
            while (!ov1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("s1_latency", 32'(n),  32'd1);
            check("s1_out",     o1,      32'd0);
            check("s1_carry",   32'(c1), 32'd1);
            check("s1_ovf",     32'(v1), 32'd0);
        end

        // 32-bit, 32 stages: latency 32.
        begin
            int n;
            @(negedge clk);
            a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; iv32 = 1'b1;
            @(negedge clk);
            iv32 = 1'b0;
            n = 1;
            while (!ov32 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("s32_latency", 32'(n),   32'd32);
            check("s32_out",     o32,      32'd0);
            check("s32_carry",   32'(c32), 32'd1);
            check("s32_ovf",     32'(v32), 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
